// File: rtl/sprite_rom_arbiter.sv
// Shares one sprite ROM read port among three renderers. Requester 0 has priority during active video; otherwise round-robin.
// gnt arrives 1 cycle after req and rvalid ROM_LATENCY+1 cycles after gnt; one read per cycle with no stalls, so requesters must always accept rvalid.
module sprite_rom_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int ROM_LATENCY = 2
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   active_video,
  input  logic [2:0]             req,
  input  logic [2:0][ADDR_W-1:0] addr,
  output logic [2:0]             gnt,
  output logic [2:0]             rvalid,
  output logic [DATA_W-1:0]      rdata,
  output logic                   rom_rd,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [DATA_W-1:0]      rom_q
);

  typedef struct packed {
    logic       vld;
    logic [1:0] id;
  } tag_t;

  logic [2:0] elig;
  logic       win_vld;
  logic [1:0] win_id;
  logic [2:0] scan_idx;
  logic [1:0] rr_ptr;
  logic [1:0] gnt_id;
  tag_t       tag_q [ROM_LATENCY];

  always_comb begin
    elig     = req & ~gnt;
    win_vld  = 1'b0;
    win_id   = 2'd0;
    scan_idx = 3'd0;
    if (active_video && elig[0]) begin
      win_vld = 1'b1;
    end else begin
      // Walk the ring from the far end so the slot nearest rr_ptr wins last.
      for (int i = 2; i >= 0; i--) begin
        scan_idx = {1'b0, rr_ptr} + 3'(i);
        if (scan_idx >= 3'd3) scan_idx = scan_idx - 3'd3;
        if (elig[scan_idx[1:0]]) begin
          win_vld = 1'b1;
          win_id  = scan_idx[1:0];
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      gnt      <= '0;
      rom_rd   <= 1'b0;
      rom_addr <= '0;
      rr_ptr   <= '0;
      gnt_id   <= '0;
      rvalid   <= '0;
      rdata    <= '0;
      for (int i = 0; i < ROM_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      gnt    <= win_vld ? 3'(3'b001 << win_id) : 3'b000;
      rom_rd <= win_vld;
      if (win_vld) begin
        rom_addr <= addr[win_id];
        gnt_id   <= win_id;
        rr_ptr   <= (win_id == 2'd2) ? 2'd0 : win_id + 2'd1;
      end
      // Tag follows the read through the ROM pipeline so data returns to its owner.
      tag_q[0] <= {rom_rd, gnt_id};
      for (int i = 1; i < ROM_LATENCY; i++) tag_q[i] <= tag_q[i-1];
      rvalid <= tag_q[ROM_LATENCY-1].vld ? 3'(3'b001 << tag_q[ROM_LATENCY-1].id) : 3'b000;
      if (tag_q[ROM_LATENCY-1].vld) rdata <= rom_q;
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Self-checking bench: randomized and directed stimulus against a queue-based reference model of the arbiter.
module tb_sprite_rom_arbiter;
  localparam int L = 2;

  logic             Clk = 1'b0;
  logic             Reset_n = 1'b0;
  logic             active_video = 1'b0;
  logic [2:0]       req = 3'b000;
  logic [2:0][15:0] addr = '0;
  logic [2:0]       gnt, rvalid;
  logic [7:0]       rdata, rom_q;
  logic             rom_rd;
  logic [15:0]      rom_addr;

  int checks = 0;
  int errors = 0;

  sprite_rom_arbiter #(.ADDR_W(16), .DATA_W(8), .ROM_LATENCY(L)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .active_video(active_video), .req(req), .addr(addr),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_q(rom_q)
  );

  always #10 Clk = ~Clk;

  // ROM: address sampled on the edge after the rom_rd cycle, data valid L cycles after rom_rd.
  logic [7:0] mem [65536];
  logic [7:0] rom_pipe [L];
  always @(posedge Clk) begin
    rom_pipe[0] <= mem[rom_addr];
    for (int i = 1; i < L; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_q = rom_pipe[L-1];

  // Reference model: grants chosen by the priority/round-robin rules, returns scheduled by due cycle.
  typedef struct { int due; int id; logic [7:0] data; } ret_t;
  ret_t        pend[$];
  int          cyc;
  int          m_ptr;
  logic [2:0]  m_gnt, m_rvalid;
  logic        m_rd;
  logic [15:0] m_addr;
  logic [7:0]  m_rdata;

  function automatic void model_reset();
    m_gnt = 0; m_rvalid = 0; m_rd = 0; m_addr = 0; m_rdata = 0; m_ptr = 0; cyc = 0;
    pend.delete();
  endfunction

  function automatic void model_step();
    int w;
    logic [2:0] e;
    cyc++;
    m_rvalid = 0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      m_rvalid = 3'(1 << pend[0].id);
      m_rdata  = pend[0].data;
      void'(pend.pop_front());
    end
    e = req & ~m_gnt;
    w = -1;
    if (active_video && e[0]) w = 0;
    else for (int i = 0; i < 3; i++) if (w < 0 && e[(m_ptr + i) % 3]) w = (m_ptr + i) % 3;
    if (w >= 0) begin
      m_gnt  = 3'(1 << w);
      m_rd   = 1'b1;
      m_addr = addr[w];
      m_ptr  = (w + 1) % 3;
      pend.push_back('{cyc + L + 1, w, mem[addr[w]]});
    end else begin
      m_gnt = 0;
      m_rd  = 1'b0;
    end
  endfunction

  task automatic tick();
    @(posedge Clk);
    if (Reset_n) model_step();
    @(negedge Clk);
  endtask

  task automatic test_reset();
    logic [2:0] exp_seq [4];
    exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001};
    model_reset();
    Reset_n = 1'b0; req = 3'b111; active_video = 1'b0;
    tick(); tick();
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt got=%b exp=000", gnt); end
    checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL reset_rvalid got=%b exp=000", rvalid); end
    checks++; if (rom_rd !== 1'b0) begin errors++; $display("FAIL reset_rom_rd got=%b exp=0", rom_rd); end
    checks++; if (rom_addr !== 16'h0) begin errors++; $display("FAIL reset_rom_addr got=%h exp=0000", rom_addr); end
    checks++; if (rdata !== 8'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
    Reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (gnt !== exp_seq[i]) begin errors++; $display("FAIL reset_rr_order step=%0d got=%b exp=%b", i, gnt, exp_seq[i]); end
    end
    req = 3'b000;
    repeat (L + 4) tick();
  endtask

  task automatic test_single();
    req = 3'b010; addr[1] = 16'h0123;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) begin
        checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL single_gnt got=%b exp=010", gnt); end
        checks++; if (rom_rd !== 1'b1 || rom_addr !== 16'h0123) begin errors++; $display("FAIL single_issue got rd=%b addr=%h exp rd=1 addr=0123", rom_rd, rom_addr); end
        req = 3'b000;
      end else if (c == 4) begin
        checks++; if (rvalid !== 3'b010 || rdata !== 8'h5A) begin errors++; $display("FAIL single_return got rv=%b rdata=%h exp rv=010 rdata=5a", rvalid, rdata); end
      end else begin
        checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL single_no_rvalid c=%0d got=%b exp=000", c, rvalid); end
      end
    end
  endtask

  task automatic test_priority();
    active_video = 1'b1; req = 3'b111;
    addr[0] = 16'h0A00; addr[1] = 16'h0B11; addr[2] = 16'h0C22;
    for (int c = 1; c <= 32; c++) begin
      if (c > 16) req[0] = 1'($urandom_range(1, 0));
      tick();
      checks++;
      if ({gnt, rom_rd, rom_addr, rvalid, rdata} !== {m_gnt, m_rd, m_addr, m_rvalid, m_rdata}) begin
        errors++;
        $display("FAIL prio_model c=%0d got gnt/rd/addr/rv/rdata=%b/%b/%h/%b/%h exp=%b/%b/%h/%b/%h",
                 c, gnt, rom_rd, rom_addr, rvalid, rdata, m_gnt, m_rd, m_addr, m_rvalid, m_rdata);
      end
      if (c <= 16) begin
        checks++;
        if (gnt[0] !== 1'(c % 2)) begin errors++; $display("FAIL prio_req0 c=%0d got gnt=%b exp gnt[0]=%0d", c, gnt, c % 2); end
      end
    end
    req = 3'b000; active_video = 1'b0;
    repeat (L + 4) tick();
  endtask

  task automatic test_hold_past_gnt();
    int n_g = 0, n_r = 0;
    logic prev = 1'b0;
    req = 3'b100; addr[2] = 16'h0077;
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c == 8) req = 3'b000;
      checks++;
      if (gnt[2] && prev) begin errors++; $display("FAIL hold_consecutive c=%0d got gnt=%b on consecutive cycles exp gap>=2", c, gnt); end
      checks++;
      if (rvalid !== m_rvalid || gnt !== m_gnt) begin errors++; $display("FAIL hold_model c=%0d got gnt=%b rv=%b exp gnt=%b rv=%b", c, gnt, rvalid, m_gnt, m_rvalid); end
      prev = gnt[2];
      if (gnt[2]) n_g++;
      if (rvalid[2]) n_r++;
    end
    checks++; if (n_g != 4) begin errors++; $display("FAIL hold_gnt_count got=%0d exp=4", n_g); end
    checks++; if (n_r != n_g) begin errors++; $display("FAIL hold_rvalid_count got=%0d exp=%0d", n_r, n_g); end
  endtask

  task automatic test_burst();
    int n_g = 0, n_r = 0, next_a = 3;
    active_video = 1'b0;
    addr[0] = 16'd0; addr[1] = 16'd1; addr[2] = 16'd2; req = 3'b111;
    for (int c = 1; c <= 20; c++) begin
      tick();
      checks++;
      if ({gnt, rom_rd, rom_addr, rvalid, rdata} !== {m_gnt, m_rd, m_addr, m_rvalid, m_rdata}) begin
        errors++;
        $display("FAIL burst_model c=%0d got gnt/rd/addr/rv/rdata=%b/%b/%h/%b/%h exp=%b/%b/%h/%b/%h",
                 c, gnt, rom_rd, rom_addr, rvalid, rdata, m_gnt, m_rd, m_addr, m_rvalid, m_rdata);
      end
      if (gnt != 3'b000) n_g++;
      if (rvalid != 3'b000) n_r++;
      for (int k = 0; k < 3; k++) begin
        if (m_gnt[k]) begin
          if (next_a < 6) begin addr[k] = 16'(next_a); next_a++; end
          else req[k] = 1'b0;
        end
      end
    end
    checks++; if (n_g != 6) begin errors++; $display("FAIL burst_gnt_count got=%0d exp=6", n_g); end
    checks++; if (n_r != 6) begin errors++; $display("FAIL burst_rvalid_count got=%0d exp=6", n_r); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if (c % 8 == 0) active_video = 1'($urandom_range(1, 0));
      for (int k = 0; k < 3; k++) begin
        if (req[k] && m_gnt[k]) begin
          if ($urandom_range(3, 0) != 0) req[k] = 1'b0;
        end else if (req[k]) begin
          if ($urandom_range(15, 0) == 0) req[k] = 1'b0;
        end else if ($urandom_range(1, 0) == 1) begin
          req[k] = 1'b1;
          addr[k] = 16'($urandom);
        end
      end
      tick();
      checks++;
      if ({gnt, rom_rd, rom_addr, rvalid, rdata} !== {m_gnt, m_rd, m_addr, m_rvalid, m_rdata}) begin
        errors++;
        $display("FAIL rnd_model c=%0d got gnt/rd/addr/rv/rdata=%b/%b/%h/%b/%h exp=%b/%b/%h/%b/%h",
                 c, gnt, rom_rd, rom_addr, rvalid, rdata, m_gnt, m_rd, m_addr, m_rvalid, m_rdata);
      end
    end
    req = 3'b000; active_video = 1'b0;
    repeat (L + 4) tick();
  endtask

  task automatic test_reset_midflight();
    active_video = 1'b0; req = 3'b011; addr[0] = 16'h0010; addr[1] = 16'h0011;
    for (int c = 1; c <= 2; c++) begin
      tick();
      for (int k = 0; k < 3; k++) if (m_gnt[k]) req[k] = 1'b0;
    end
    Reset_n = 1'b0;
    model_reset();
    #1;
    checks++; if (gnt !== 3'b000 || rom_rd !== 1'b0 || rvalid !== 3'b000) begin errors++; $display("FAIL midrst_async got gnt=%b rd=%b rv=%b exp 000/0/000", gnt, rom_rd, rvalid); end
    tick(); tick();
    Reset_n = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL midrst_flushed c=%0d got rv=%b exp=000", c, rvalid); end
    end
    req = 3'b110; addr[1] = 16'h0042; addr[2] = 16'h0099;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) begin
        checks++; if (gnt !== 3'b010 || rom_addr !== 16'h0042) begin errors++; $display("FAIL midrst_ptr got gnt=%b addr=%h exp gnt=010 addr=0042", gnt, rom_addr); end
        req = 3'b000;
      end else if (c == 4) begin
        checks++; if (rvalid !== 3'b010 || rdata !== mem[16'h0042]) begin errors++; $display("FAIL midrst_return got rv=%b rdata=%h exp rv=010 rdata=%h", rvalid, rdata, mem[16'h0042]); end
      end else begin
        checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL midrst_idle c=%0d got rv=%b exp=000", c, rvalid); end
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'((a * 37) ^ (a >> 8) ^ 8'h3C);
    mem[16'h0123] = 8'h5A;
    test_reset();
    test_single();
    test_priority();
    test_hold_past_gnt();
    test_burst();
    test_random();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
